// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flex
// Description : Single-clock FIFO with register-array storage, selectable
//               registered or first-word-fall-through read, threshold flags
//               and sticky overflow/underflow indicators.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int DataWidth      = 64,
    parameter int Depth          = 16,
    parameter int Fwft           = 0,
    parameter int AlmostFullThr  = Depth - 2,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    input  logic [DataWidth-1:0]       WData,
    input  logic                       WInc,
    output logic                       WFull,
    output logic                       WAlmostFull,
    output logic [DataWidth-1:0]       RData,
    input  logic                       RInc,
    output logic                       REmpty,
    output logic                       RAlmostEmpty,
    output logic [$clog2(Depth):0]     Count,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int               c_AW      = $clog2(Depth);
    localparam logic [c_AW:0]    c_DEPTH   = (c_AW + 1)'(Depth);
    localparam logic [c_AW:0]    c_AF_THR  = (c_AW + 1)'(AlmostFullThr);
    localparam logic [c_AW:0]    c_AE_THR  = (c_AW + 1)'(AlmostEmptyThr);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [c_AW:0]        r_wptr;
    logic [c_AW:0]        r_rptr;
    logic [c_AW:0]        r_count;
    logic                 r_ovf;
    logic                 r_udf;
    logic                 w_wr;
    logic                 w_rd;
    logic [DataWidth-1:0] w_head;

    assign WFull        = (r_count == c_DEPTH);
    assign REmpty       = (r_count == '0);
    assign WAlmostFull  = (r_count >= c_AF_THR);
    assign RAlmostEmpty = (r_count <= c_AE_THR);
    assign Count        = r_count;
    assign Overflow     = r_ovf;
    assign Underflow    = r_udf;

    // A full FIFO refuses writes even when a read frees a slot on the same edge.
    assign w_wr   = WInc & ~WFull  & ~Flush;
    assign w_rd   = RInc & ~REmpty & ~Flush;
    assign w_head = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= WData;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (Flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (WInc && WFull) begin
                r_ovf <= 1'b1;
            end
            if (RInc && REmpty) begin
                r_udf <= 1'b1;
            end
        end
    end

    generate
        if (Fwft != 0) begin : g_fwft
            assign RData = REmpty ? '0 : w_head;
        end else begin : g_reg
            logic [DataWidth-1:0] r_rdata;
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_rdata <= '0;
                end else if (w_rd) begin
                    r_rdata <= w_head;
                end
            end
            assign RData = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flex
// Description : Queue-model bench driving a registered-read and an FWFT
//               instance of sync_fifo_flex with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flex;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 4;
    localparam int c_AF    = 3;
    localparam int c_AE    = 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Flush = 1'b0;
    logic [7:0] WData = '0;
    logic       WInc = 1'b0;
    logic       RInc = 1'b0;

    logic       r_wfull, r_waf, r_rempty, r_rae, r_ovf, r_udf;
    logic [7:0] r_rdata;
    logic [2:0] r_count;
    logic       f_wfull, f_waf, f_rempty, f_rae, f_ovf, f_udf;
    logic [7:0] f_rdata;
    logic [2:0] f_count;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: contents as a queue, sticky flags, last registered read.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    logic [7:0] m_rdata = '0;

    always #5 Clk = ~Clk;

    sync_fifo_flex #(
        .DataWidth(c_DW), .Depth(c_DEPTH), .Fwft(0),
        .AlmostFullThr(c_AF), .AlmostEmptyThr(c_AE)
    ) u_reg (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .WData(WData), .WInc(WInc),
        .WFull(r_wfull), .WAlmostFull(r_waf), .RData(r_rdata), .RInc(RInc),
        .REmpty(r_rempty), .RAlmostEmpty(r_rae), .Count(r_count),
        .Overflow(r_ovf), .Underflow(r_udf)
    );

    sync_fifo_flex #(
        .DataWidth(c_DW), .Depth(c_DEPTH), .Fwft(1),
        .AlmostFullThr(c_AF), .AlmostEmptyThr(c_AE)
    ) u_fwft (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .WData(WData), .WInc(WInc),
        .WFull(f_wfull), .WAlmostFull(f_waf), .RData(f_rdata), .RInc(RInc),
        .REmpty(f_rempty), .RAlmostEmpty(f_rae), .Count(f_count),
        .Overflow(f_ovf), .Underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_rdata = '0;
        end else if (Flush) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit full, empty;
            full  = (m_q.size() == c_DEPTH);
            empty = (m_q.size() == 0);
            if (WInc && full)  m_ovf = 1'b1;
            if (RInc && empty) m_udf = 1'b1;
            if (RInc && !empty) m_rdata = m_q.pop_front();
            if (WInc && !full)  m_q.push_back(WData);
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            int sz;
            logic [7:0] head;
            sz   = m_q.size();
            head = (sz == 0) ? 8'h00 : m_q[0];
            chk("count_reg",   32'(r_count),  32'(sz));
            chk("count_fwft",  32'(f_count),  32'(sz));
            chk("wfull",       32'(r_wfull & f_wfull),   32'(sz == c_DEPTH));
            chk("wfull_or",    32'(r_wfull | f_wfull),   32'(sz == c_DEPTH));
            chk("walmostfull", 32'({r_waf, f_waf}),      32'({2{sz >= c_AF}}));
            chk("rempty",      32'({r_rempty, f_rempty}), 32'({2{sz == 0}}));
            chk("ralmostempty",32'({r_rae, f_rae}),      32'({2{sz <= c_AE}}));
            chk("overflow",    32'({r_ovf, f_ovf}),      32'({2{m_ovf}}));
            chk("underflow",   32'({r_udf, f_udf}),      32'({2{m_udf}}));
            chk("rdata_reg",   32'(r_rdata),  32'(m_rdata));
            chk("rdata_fwft",  32'(f_rdata),  32'(head));
        end
    end

    task automatic step(input bit wi, input bit ri, input bit fl, input logic [7:0] wd);
        @(negedge Clk);
        WInc  = wi;
        RInc  = ri;
        Flush = fl;
        WData = wd;
    endtask

    task automatic post();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", 32'(r_count), 32'd0);
        chk("rst_flags", 32'({r_rempty, r_rae, r_wfull, r_waf, r_ovf, r_udf}), 32'b110000);
        chk("rst_rdata", 32'({r_rdata, f_rdata}), 32'h0000);
        @(negedge Clk);
        Rst    = 1'b0;
        chk_en = 1'b1;

        // Fill to full, then one more write overflows without disturbing contents.
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        step(1, 0, 0, 8'h44);
        post();
        chk("fill_count", 32'(r_count), 32'd4);
        chk("fill_full",  32'({r_wfull, r_waf}), 32'b11);
        step(1, 0, 0, 8'h55);
        post();
        chk("ovf_set",   32'(r_ovf), 32'd1);
        chk("ovf_count", 32'(f_count), 32'd4);
        chk("ovf_head",  32'(f_rdata), 32'h11);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        post();
        chk("drain_last", 32'(r_rdata), 32'h44);
        step(0, 0, 1, 8'h00);

        // Registered read of the head word, held while idle.
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(0, 1, 0, 8'h00);
        post();
        chk("rd_data",  32'(r_rdata), 32'h11);
        chk("rd_count", 32'({r_count, r_rae}), 32'({3'd1, 1'b1}));
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        post();
        chk("rd_hold", 32'(r_rdata), 32'h11);

        // Fall-through presentation of a word written to an empty FIFO.
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'hA5);
        step(0, 0, 0, 8'h00);
        chk("fwft_show", 32'({f_rempty, f_rdata}), 32'({1'b0, 8'hA5}));
        step(0, 1, 0, 8'h00);
        post();
        chk("fwft_pop", 32'({f_rempty, f_rdata}), 32'({1'b1, 8'h00}));

        // Move pointers to index 3, hold two entries, stream across the wrap.
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'hC0);
        step(1, 0, 0, 8'hC1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'(8'hD0 + i));
        post();
        chk("wrap_count", 32'(r_count), 32'd2);
        chk("wrap_rdata", 32'(r_rdata), 32'hD1);
        chk("wrap_head",  32'(f_rdata), 32'hD2);

        // Flush with simultaneous requests on a 3-deep FIFO with Overflow set.
        step(1, 0, 0, 8'hE0);
        step(1, 0, 0, 8'hE1);
        step(1, 0, 0, 8'hE2);
        step(0, 1, 0, 8'h00);
        post();
        chk("pre_flush", 32'({r_count, r_ovf}), 32'({3'd3, 1'b1}));
        step(1, 1, 1, 8'hEE);
        post();
        chk("flush", 32'({r_count, r_rempty, r_ovf, f_rempty}), 32'({3'd0, 1'b1, 1'b0, 1'b1}));
        step(0, 1, 0, 8'h00);
        post();
        chk("udf_set", 32'(f_udf), 32'd1);

        // Asynchronous reset between edges with three entries stored.
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(1, 0, 0, 8'h03);
        step(0, 0, 0, 8'h00);
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_flags", 32'({r_count, r_rempty, r_rae, r_wfull, r_waf, r_udf}),
            32'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("arst_rdata", 32'({r_rdata, f_rdata}), 32'h0000);
        step(1, 0, 0, 8'h77);
        Rst = 1'b0;
        post();
        chk("arst_resume", 32'(f_count), 32'd1);
        chk("arst_head",   32'(f_rdata), 32'h77);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 2), 8'($urandom));
        end
        step(0, 0, 0, 8'h00);
        post();
        @(negedge Clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter DataWidth, default 64, entry width in bits.
REQ-002 SHALL have parameter Depth, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter Fwft, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AlmostFullThr, default Depth-2, WAlmostFull threshold in entries.
REQ-005 SHALL have parameter AlmostEmptyThr, default 2, RAlmostEmpty threshold in entries.
REQ-006 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port Flush, input, 1, synchronous clear of contents and sticky flags.
REQ-009 SHALL have port WData, input, DataWidth, write data.
REQ-010 SHALL have port WInc, input, 1, write request.
REQ-011 SHALL have port WFull, output, 1, no free entries.
REQ-012 SHALL have port WAlmostFull, output, 1, Count >= AlmostFullThr.
REQ-013 SHALL have port RData, output, DataWidth, read data.
REQ-014 SHALL have port RInc, input, 1, read request (Fwft=1: pop of the presented word).
REQ-015 SHALL have port REmpty, output, 1, no stored entries.
REQ-016 SHALL have port RAlmostEmpty, output, 1, Count <= AlmostEmptyThr.
REQ-017 SHALL have port Count, output, $clog2(Depth)+1, current occupancy 0..Depth.
REQ-018 SHALL have port Overflow, output, 1, sticky: write attempted while full.
REQ-019 SHALL have port Underflow, output, 1, sticky: read attempted while empty.

Function
REQ-020 SHALL hold storage internally as a Depth x DataWidth register array; no external RAM.
REQ-021 SHALL use read/write pointers of $clog2(Depth)+1 bits with an extra wrap bit; index = low bits; wrap naturally modulo 2*Depth.
REQ-022 SHALL accept a write iff WInc=1, WFull=0, Flush=0: store WData at write index, increment write pointer.
REQ-023 SHALL accept a read iff RInc=1, REmpty=0, Flush=0: increment read pointer.
REQ-024 SHALL NOT accept a write while full even with a simultaneous accepted read.
REQ-025 SHALL update Count +1 on write only, -1 on read only, unchanged on both or neither; Count registered.
REQ-026 SHALL derive WFull (Count==Depth), REmpty (Count==0), WAlmostFull, RAlmostEmpty combinationally from registered state; flags track Count with no extra latency.
REQ-027 SHALL, when Fwft=0, load RData with the head entry on the edge a read is accepted; otherwise RData holds.
REQ-028 SHALL, when Fwft=1, drive RData combinationally with the head entry while REmpty=0 and 0 while REmpty=1; a word written to an empty FIFO appears the cycle after its write edge.
REQ-029 SHALL set Overflow on an edge with WInc=1, WFull=1, Flush=0; set Underflow on RInc=1, REmpty=1, Flush=0; both hold until Flush or Rst.
REQ-030 SHALL, on an edge with Flush=1, zero both pointers, Count, Overflow, Underflow, ignore WInc/RInc that cycle; array contents and RData (Fwft=0) unaffected.
REQ-031 SHALL preserve strict FIFO order across pointer wrap-around.

Reset
REQ-032 SHALL, on Rst=1 at any time, immediately force pointers=0, Count=0, REmpty=1, RAlmostEmpty=1, WFull=0, WAlmostFull=0 (AlmostFullThr>0), Overflow=0, Underflow=0, RData=0; array not reset.
REQ-033 SHALL resume normal operation on the first rising Clk edge after Rst deasserts.

Verification (Depth=4, DataWidth=8, thresholds 3/1)
REQ-034 Write 0x11,0x22,0x33,0x44 -> Count=4, WFull=1, WAlmostFull=1 after 4th edge; 5th WInc -> Overflow=1, Count=4, contents unchanged.
REQ-035 Fwft=0, FIFO holds 0x11,0x22: RInc one cycle -> RData=0x11 after edge, Count=1, RAlmostEmpty=1; RData holds 0x11 with RInc=0.
REQ-036 Fwft=1, empty: write 0xA5 -> next cycle REmpty=0, RData=0xA5 with no RInc; RInc -> REmpty=1, RData=0.
REQ-037 Count=2 at pointer index 3: WInc+RInc for 4 cycles -> Count stays 2, read order matches write order across wrap.
REQ-038 Count=3, Overflow=1, Flush=WInc=RInc=1 -> next edge Count=0, REmpty=1, Overflow=0, no data stored.
REQ-039 Count=3, Rst asserted between edges -> outputs take reset values before next edge; after release first write yields Count=1.
